// File: rtl/ex_mem_pkg.sv
// Shared constants, result record and stall-mode decode for the EX/MEM pipeline register.
package ex_mem_pkg;

  localparam int REG_BUS_W      = 32;
  localparam int REG_ADDR_BUS_W = 5;
  localparam int ALU_OP_BUS_W   = 8;
  localparam int DBL_REG_BUS_W  = 64;

  localparam logic                      RST_ENABLE    = 1'b1;
  localparam logic                      STOP          = 1'b1;
  localparam logic                      NO_STOP       = 1'b0;
  localparam logic                      WRITE_ENABLE  = 1'b1;
  localparam logic                      WRITE_DISABLE = 1'b0;
  localparam logic [REG_BUS_W-1:0]      ZERO_WORD     = '0;
  localparam logic [REG_ADDR_BUS_W-1:0] NOP_REG_ADDR  = '0;
  localparam logic [ALU_OP_BUS_W-1:0]   EXE_NOP_OP    = 8'b0000_0000;

  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

  typedef enum logic [1:0] {
    MODE_PASS,
    MODE_BUBBLE,
    MODE_HOLD
  } stage_mode_e;

  typedef struct packed {
    logic [REG_ADDR_BUS_W-1:0] wd;
    logic                      wreg;
    logic [REG_BUS_W-1:0]      wdata;
    logic                      whilo;
    logic [REG_BUS_W-1:0]      hi;
    logic [REG_BUS_W-1:0]      lo;
    logic [ALU_OP_BUS_W-1:0]   aluop;
    logic [REG_BUS_W-1:0]      mem_addr;
    logic [REG_BUS_W-1:0]      reg2;
  } ex_result_t;

  // A bubble must never write the register file or HI/LO.
  localparam ex_result_t RESULT_NOP = '{
    wd:       NOP_REG_ADDR,
    wreg:     WRITE_DISABLE,
    wdata:    ZERO_WORD,
    whilo:    WRITE_DISABLE,
    hi:       ZERO_WORD,
    lo:       ZERO_WORD,
    aluop:    EXE_NOP_OP,
    mem_addr: ZERO_WORD,
    reg2:     ZERO_WORD
  };

  // ex running -> pass; ex stopped but mem running -> bubble; both stopped -> hold.
  function automatic stage_mode_e stage_mode(input logic ex_stop, input logic mem_stop);
    if (ex_stop != STOP)  return MODE_PASS;
    if (mem_stop != STOP) return MODE_BUBBLE;
    return MODE_HOLD;
  endfunction

endpackage

// File: rtl/ex_mem.sv
// EX/MEM pipeline register: pass, bubble or hold under the ctrl stall vector,
// and madd/msub intermediate feedback to ex. Optional flush port: EX_MEM_FLUSH_EN.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int STALL_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef EX_MEM_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [STALL_W-1:0]        stall,
  input  logic [REG_ADDR_BUS_W-1:0] ex_wd,
  input  logic                      ex_wreg,
  input  logic [REG_BUS_W-1:0]      ex_wdata,
  input  logic                      ex_whilo,
  input  logic [REG_BUS_W-1:0]      ex_hi,
  input  logic [REG_BUS_W-1:0]      ex_lo,
  input  logic [ALU_OP_BUS_W-1:0]   ex_aluop,
  input  logic [REG_BUS_W-1:0]      ex_mem_addr,
  input  logic [REG_BUS_W-1:0]      ex_reg2,
  input  logic [DBL_REG_BUS_W-1:0]  hilo_i,
  input  logic [1:0]                cnt_i,
  output logic [REG_ADDR_BUS_W-1:0] mem_wd,
  output logic                      mem_wreg,
  output logic [REG_BUS_W-1:0]      mem_wdata,
  output logic                      mem_whilo,
  output logic [REG_BUS_W-1:0]      mem_hi,
  output logic [REG_BUS_W-1:0]      mem_lo,
  output logic [ALU_OP_BUS_W-1:0]   mem_aluop,
  output logic [REG_BUS_W-1:0]      mem_mem_addr,
  output logic [REG_BUS_W-1:0]      mem_reg2,
  output logic [DBL_REG_BUS_W-1:0]  hilo_o,
  output logic [1:0]                cnt_o
);

  ex_result_t               ex_res;
  ex_result_t               res_q;
  logic [DBL_REG_BUS_W-1:0] hilo_q;
  logic [1:0]               cnt_q;
  logic                     clear;
  logic                     stall_unused;

  // Only the ex and mem stop bits matter to this stage.
  assign stall_unused = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

`ifdef EX_MEM_FLUSH_EN
  assign clear = (rst == RST_ENABLE) || flush;
`else
  assign clear = (rst == RST_ENABLE);
`endif

  always_comb begin
    ex_res = '{
      wd:       ex_wd,
      wreg:     ex_wreg,
      wdata:    ex_wdata,
      whilo:    ex_whilo,
      hi:       ex_hi,
      lo:       ex_lo,
      aluop:    ex_aluop,
      mem_addr: ex_mem_addr,
      reg2:     ex_reg2
    };
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (clear) begin
      res_q  <= RESULT_NOP;
      hilo_q <= '0;
      cnt_q  <= '0;
    end else begin
      unique case (stage_mode(stall[STALL_EX], stall[STALL_MEM]))
        MODE_PASS: begin
          res_q  <= ex_res;
          hilo_q <= '0;
          cnt_q  <= '0;
        end
        MODE_BUBBLE: begin
          res_q  <= RESULT_NOP;
          hilo_q <= hilo_i;
          cnt_q  <= cnt_i;
        end
        default: ;  // hold: every register keeps its value
      endcase
    end
  end

  assign mem_wd       = res_q.wd;
  assign mem_wreg     = res_q.wreg;
  assign mem_wdata    = res_q.wdata;
  assign mem_whilo    = res_q.whilo;
  assign mem_hi       = res_q.hi;
  assign mem_lo       = res_q.lo;
  assign mem_aluop    = res_q.aluop;
  assign mem_mem_addr = res_q.mem_addr;
  assign mem_reg2     = res_q.reg2;
  assign hilo_o       = hilo_q;
  assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Self-checking bench for ex_mem: directed plan items plus randomized stall/data
// traffic compared against a slot-level reference model.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  stall = '0;
  logic [4:0]  ex_wd = '0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic [7:0]  ex_aluop = '0;
  logic [31:0] ex_mem_addr = '0;
  logic [31:0] ex_reg2 = '0;
  logic [63:0] hilo_i = '0;
  logic [1:0]  cnt_i = '0;

  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int n_vec  = 0;
  int n_miss = 0;

  ex_mem dut (
    .clk          (clk),
    .rst          (rst),
`ifdef EX_MEM_FLUSH_EN
    .flush        (flush),
`endif
    .stall        (stall),
    .ex_wd        (ex_wd),
    .ex_wreg      (ex_wreg),
    .ex_wdata     (ex_wdata),
    .ex_whilo     (ex_whilo),
    .ex_hi        (ex_hi),
    .ex_lo        (ex_lo),
    .ex_aluop     (ex_aluop),
    .ex_mem_addr  (ex_mem_addr),
    .ex_reg2      (ex_reg2),
    .hilo_i       (hilo_i),
    .cnt_i        (cnt_i),
    .mem_wd       (mem_wd),
    .mem_wreg     (mem_wreg),
    .mem_wdata    (mem_wdata),
    .mem_whilo    (mem_whilo),
    .mem_hi       (mem_hi),
    .mem_lo       (mem_lo),
    .mem_aluop    (mem_aluop),
    .mem_mem_addr (mem_mem_addr),
    .mem_reg2     (mem_reg2),
    .hilo_o       (hilo_o),
    .cnt_o        (cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: the mem slot holds either an instruction record (the ex
  // fields as a list) or a bubble; the feedback pair is tracked separately.
  logic [31:0] slot [9];
  logic [63:0] m_hilo = '0;
  logic [1:0]  m_cnt  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit cleared;
    cleared = rst;
`ifdef EX_MEM_FLUSH_EN
    cleared = cleared || flush;
`endif
    if (cleared) begin
      foreach (slot[i]) slot[i] = '0;
      m_hilo = '0;
      m_cnt  = '0;
    end else if (stall[3] == 1'b0) begin
      if (stall[4]) $display("note: protocol error, non-monotonic stall %b taken as pass", stall);
      slot = '{32'(ex_wd), 32'(ex_wreg), ex_wdata, 32'(ex_whilo), ex_hi, ex_lo,
               32'(ex_aluop), ex_mem_addr, ex_reg2};
      m_hilo = '0;
      m_cnt  = '0;
    end else if (stall[4] == 1'b0) begin
      foreach (slot[i]) slot[i] = '0;
      m_hilo = hilo_i;
      m_cnt  = cnt_i;
    end
  endtask

  task automatic compare_all();
    check("mem_wd",       64'(mem_wd),       64'(slot[0]));
    check("mem_wreg",     64'(mem_wreg),     64'(slot[1]));
    check("mem_wdata",    64'(mem_wdata),    64'(slot[2]));
    check("mem_whilo",    64'(mem_whilo),    64'(slot[3]));
    check("mem_hi",       64'(mem_hi),       64'(slot[4]));
    check("mem_lo",       64'(mem_lo),       64'(slot[5]));
    check("mem_aluop",    64'(mem_aluop),    64'(slot[6]));
    check("mem_mem_addr", 64'(mem_mem_addr), 64'(slot[7]));
    check("mem_reg2",     64'(mem_reg2),     64'(slot[8]));
    check("hilo_o",       hilo_o,            m_hilo);
    check("cnt_o",        64'(cnt_o),        64'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic rand_ex();
    ex_wd       = 5'($urandom);
    ex_wreg     = 1'($urandom);
    ex_wdata    = $urandom;
    ex_whilo    = 1'($urandom);
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_aluop    = 8'($urandom);
    ex_mem_addr = $urandom;
    ex_reg2     = $urandom;
    hilo_i      = {$urandom, $urandom};
    cnt_i       = 2'($urandom);
  endtask

  task automatic all_ones_ex();
    ex_wd = '1; ex_wreg = 1'b1; ex_wdata = '1; ex_whilo = 1'b1; ex_hi = '1; ex_lo = '1;
    ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1; hilo_i = '1; cnt_i = 2'b11;
  endtask

  initial begin
    int r;
    foreach (slot[i]) slot[i] = '0;

    // Reset with every input non-zero and stall asserted.
    all_ones_ex();
    stall = 6'b011111;
    flush = 1'b1;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    check("reset_aluop_nop", 64'(mem_aluop), 64'h0);

    // Plain pass.
    rand_ex();
    stall = '0; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h0000_1234;
    tick();
    check("pass_wdata", 64'(mem_wdata), 64'h1234);

    // madd cycle 1: bubble latches the product and counter.
    rand_ex();
    stall = 6'b001111; hilo_i = 64'h1_0000_0002; cnt_i = 2'b01; ex_wreg = 1'b1; ex_whilo = 1'b1;
    tick();
    check("bubble_wreg", 64'(mem_wreg), 64'h0);
    check("bubble_hilo", hilo_o, 64'h1_0000_0002);
    check("bubble_cnt", 64'(cnt_o), 64'h1);

    // madd cycle 2: stall dropped, pass clears feedback.
    rand_ex();
    stall = '0; cnt_i = 2'b10;
    tick();
    check("madd2_cnt", 64'(cnt_o), 64'h0);

    // Hold: load DEADBEEF then freeze for three cycles under changing inputs.
    rand_ex();
    ex_wdata = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      stall = 6'b011111;
      tick();
      check("hold_wdata", 64'(mem_wdata), 64'hDEAD_BEEF);
    end

    // Reset in the middle of a madd.
    rand_ex();
    stall = 6'b001111; cnt_i = 2'b01;
    tick();
    rand_ex();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_madd_cnt", 64'(cnt_o), 64'h0);

    // Unreachable cnt code is latched unchanged.
    rand_ex();
    stall = 6'b001111; cnt_i = 2'b11;
    tick();

    // Non-monotonic stall is taken as pass.
    rand_ex();
    stall = 6'b010000;
    tick();

`ifdef EX_MEM_FLUSH_EN
    rand_ex();
    stall = '0; ex_wreg = 1'b1; flush = 1'b1;
    tick();
    check("flush_wreg", 64'(mem_wreg), 64'h0);
    flush = 1'b0;
    rand_ex();
    tick();
`endif

    // Randomized traffic with monotonic stall vectors.
    for (int n = 0; n < 400; n++) begin
      rand_ex();
      r = int'($urandom_range(0, 9));
      if (r < 5)      stall = 6'b000000;
      else if (r < 8) stall = 6'b001111;
      else            stall = 6'b011111;
      rst = ($urandom_range(0, 39) == 0);
`ifdef EX_MEM_FLUSH_EN
      flush = ($urandom_range(0, 29) == 0);
`endif
      tick();
    end
    rst   = 1'b0;
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
